exe_stage: RTL and testbench

Execute stage of the 5-stage ARM pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs. It computes the second operand (Val2), the ALU result, the status flags and the branch target. It holds the NZCV status register and the EX/MEM pipeline register that feeds the memory stage.

---
 rtl/exe_if.sv | 53 +++++
 rtl/exe_stage.sv | 122 ++++++++++++
 tb/tb_exe_stage.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exe_if.sv
// Bundle between ID/EX register, execute stage and downstream consumers.
// Forwarding signals exist only when FORWARDING_EN is defined.
interface exe_if;
  logic        WB_EN;
  logic        Mem_R_EN;
  logic        Mem_W_EN;
  logic [3:0]  EXE_CMD;
  logic        B;
  logic        S;
  logic [31:0] pc;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        imm;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic        freeze;
`ifdef FORWARDING_EN
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] MEM_ALU_result;
  logic [31:0] WB_Value;
`endif
  logic [3:0]  SR;
  logic        Branch_taken;
  logic [31:0] Branch_Address;
  logic        WB_EN_out;
  logic        Mem_R_EN_out;
  logic        Mem_W_EN_out;
  logic [31:0] ALU_result;
  logic [31:0] Val_Rm_out;
  logic [3:0]  dest_out;

  modport slave (
    input  WB_EN, Mem_R_EN, Mem_W_EN, EXE_CMD, B, S, pc, Val_Rn, Val_Rm,
           imm, shift_operand, signed_imm_24, dest, freeze,
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, MEM_ALU_result, WB_Value,
`endif
    output SR, Branch_taken, Branch_Address, WB_EN_out, Mem_R_EN_out,
           Mem_W_EN_out, ALU_result, Val_Rm_out, dest_out
  );

  modport master (
    output WB_EN, Mem_R_EN, Mem_W_EN, EXE_CMD, B, S, pc, Val_Rn, Val_Rm,
           imm, shift_operand, signed_imm_24, dest, freeze,
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, MEM_ALU_result, WB_Value,
`endif
    input  SR, Branch_taken, Branch_Address, WB_EN_out, Mem_R_EN_out,
           Mem_W_EN_out, ALU_result, Val_Rm_out, dest_out
  );
endinterface

// File: rtl/exe_stage.sv
// ARM pipeline execute stage: Val2 generation, ALU, NZCV register, EX/MEM register.
// Optional operand forwarding muxes are enabled with FORWARDING_EN.
module exe_stage (
  input  logic   clk,
  input  logic   rst,
  exe_if.slave   bus
);
  localparam int unsigned DW = 32;

  logic [DW-1:0] rn, rm, val2, res, imm_x;
  logic [DW:0]   sum;
  logic [4:0]    sh_amt;
  logic          cin, c_new, v_new, flag_upd;
  logic [3:0]    sr_q;
  logic          wb_q, mr_q, mw_q;
  logic [DW-1:0] res_q, rm_q;
  logic [3:0]    dest_q;

  function automatic logic [DW-1:0] ror32(input logic [DW-1:0] x, input logic [4:0] a);
    return (x >> a) | (x << (6'd32 - {1'b0, a}));
  endfunction

`ifdef FORWARDING_EN
  always_comb begin
    rn = bus.Val_Rn;
    rm = bus.Val_Rm;
    case (bus.sel_src1)
      2'b01:   rn = bus.MEM_ALU_result;
      2'b10:   rn = bus.WB_Value;
      default: rn = bus.Val_Rn;
    endcase
    case (bus.sel_src2)
      2'b01:   rm = bus.MEM_ALU_result;
      2'b10:   rm = bus.WB_Value;
      default: rm = bus.Val_Rm;
    endcase
  end
`else
  assign rn = bus.Val_Rn;
  assign rm = bus.Val_Rm;
`endif

  // Second operand: rotated immediate, memory offset, or immediate-shifted register
  assign imm_x  = {24'b0, bus.shift_operand[7:0]};
  assign sh_amt = bus.shift_operand[11:7];
  always_comb begin
    val2 = rm;
    if (bus.imm) begin
      val2 = ror32(imm_x, {bus.shift_operand[11:8], 1'b0});
    end else if (bus.Mem_R_EN || bus.Mem_W_EN) begin
      val2 = {20'b0, bus.shift_operand};
    end else begin
      case (bus.shift_operand[6:5])
        2'b00:   val2 = rm << sh_amt;
        2'b01:   val2 = rm >> sh_amt;
        2'b10:   val2 = DW'($signed(rm) >>> sh_amt);
        default: val2 = ror32(rm, sh_amt);
      endcase
    end
  end

  assign cin = sr_q[1];

  // ALU; C and V default to stored values so logical ops preserve them
  always_comb begin
    sum      = '0;
    res      = '0;
    c_new    = sr_q[1];
    v_new    = sr_q[0];
    flag_upd = 1'b1;
    case (bus.EXE_CMD)
      4'b0001: res = val2;
      4'b1001: res = ~val2;
      4'b0010, 4'b0011: begin
        sum   = {1'b0, rn} + {1'b0, val2} + ((bus.EXE_CMD == 4'b0011) ? 33'(cin) : 33'd0);
        res   = sum[DW-1:0];
        c_new = sum[DW];
        v_new = (rn[DW-1] == val2[DW-1]) && (res[DW-1] != rn[DW-1]);
      end
      4'b0100, 4'b0101: begin
        sum   = {1'b0, rn} + {1'b0, ~val2} + ((bus.EXE_CMD == 4'b0101) ? 33'(cin) : 33'd1);
        res   = sum[DW-1:0];
        c_new = sum[DW];
        v_new = (rn[DW-1] != val2[DW-1]) && (res[DW-1] != rn[DW-1]);
      end
      4'b0110: res = rn & val2;
      4'b0111: res = rn | val2;
      4'b1000: res = rn ^ val2;
      default: flag_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      wb_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      res_q  <= '0;
      rm_q   <= '0;
      dest_q <= '0;
    end else if (!bus.freeze) begin
      if (bus.S && flag_upd) sr_q <= {res[DW-1], (res == '0), c_new, v_new};
      wb_q   <= bus.WB_EN;
      mr_q   <= bus.Mem_R_EN;
      mw_q   <= bus.Mem_W_EN;
      res_q  <= res;
      rm_q   <= rm;
      dest_q <= bus.dest;
    end
  end

  assign bus.SR             = sr_q;
  assign bus.WB_EN_out      = wb_q;
  assign bus.Mem_R_EN_out   = mr_q;
  assign bus.Mem_W_EN_out   = mw_q;
  assign bus.ALU_result     = res_q;
  assign bus.Val_Rm_out     = rm_q;
  assign bus.dest_out       = dest_q;
  assign bus.Branch_taken   = bus.B;
  assign bus.Branch_Address = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage with hand-computed expectations.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exe_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ALU instruction with memory/branch controls cleared
  task automatic drive(input logic [3:0] cmd, input logic s, input logic im,
                       input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
    bus.EXE_CMD       = cmd;
    bus.S             = s;
    bus.imm           = im;
    bus.shift_operand = so;
    bus.Val_Rn        = rn;
    bus.Val_Rm        = rm;
    bus.WB_EN         = 1'b1;
    bus.Mem_R_EN      = 1'b0;
    bus.Mem_W_EN      = 1'b0;
    bus.B             = 1'b0;
    bus.dest          = 4'd1;
`ifdef FORWARDING_EN
    bus.sel_src1      = 2'b00;
    bus.sel_src2      = 2'b00;
`endif
  endtask

  initial begin
    bus.freeze        = 1'b0;
    bus.pc            = '0;
    bus.signed_imm_24 = '0;
`ifdef FORWARDING_EN
    bus.MEM_ALU_result = '0;
    bus.WB_Value       = '0;
`endif
    drive(4'b0001, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0);
    #12;
    chk("rst_alu", bus.ALU_result, 32'h0);
    chk("rst_sr", 32'(bus.SR), 32'h0);
    chk("rst_wb", 32'(bus.WB_EN_out), 32'h0);
    rst = 1'b0;

    drive(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h0); tick();
    chk("add_ovf_res", bus.ALU_result, 32'h80000000);
    chk("add_ovf_sr", 32'(bus.SR), 32'h9);

    drive(4'b0100, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5); tick();
    chk("cmp_res", bus.ALU_result, 32'h0);
    chk("cmp_sr", 32'(bus.SR), 32'h6);

    drive(4'b0110, 1'b1, 1'b0, 12'h000, 32'hFFFFFFFF, 32'h80000000); tick();
    chk("and_res", bus.ALU_result, 32'h80000000);
    chk("and_sr_keep_cv", 32'(bus.SR), 32'hA);

    drive(4'b0011, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0); tick();
    chk("adc_res", bus.ALU_result, 32'd3);
    chk("adc_sr", 32'(bus.SR), 32'h0);

    drive(4'b0101, 1'b1, 1'b1, 12'h003, 32'd10, 32'h0); tick();
    chk("sbc_res", bus.ALU_result, 32'd6);
    chk("sbc_sr", 32'(bus.SR), 32'h2);

    drive(4'b0000, 1'b1, 1'b0, 12'h000, 32'h55, 32'h55); tick();
    chk("bad_op_res", bus.ALU_result, 32'h0);
    chk("bad_op_sr", 32'(bus.SR), 32'h2);

    drive(4'b0001, 1'b0, 1'b1, 12'h4FF, 32'h0, 32'h0); tick();
    chk("mov_rot_imm", bus.ALU_result, 32'hFF000000);
    chk("s0_sr_hold", 32'(bus.SR), 32'h2);

    drive(4'b0001, 1'b0, 1'b0, 12'h060, 32'h0, 32'h1); tick();
    chk("ror0", bus.ALU_result, 32'h1);
    drive(4'b0001, 1'b0, 1'b0, 12'h0E0, 32'h0, 32'h1); tick();
    chk("ror1", bus.ALU_result, 32'h80000000);
    drive(4'b0001, 1'b0, 1'b0, 12'h220, 32'h0, 32'h80000000); tick();
    chk("lsr4", bus.ALU_result, 32'h08000000);
    drive(4'b0001, 1'b0, 1'b0, 12'h240, 32'h0, 32'h80000000); tick();
    chk("asr4", bus.ALU_result, 32'hF8000000);
    drive(4'b0001, 1'b0, 1'b0, 12'h200, 32'h0, 32'h1); tick();
    chk("lsl4", bus.ALU_result, 32'h10);
    drive(4'b1001, 1'b0, 1'b1, 12'h000, 32'h0, 32'h0); tick();
    chk("mvn", bus.ALU_result, 32'hFFFFFFFF);
    drive(4'b1000, 1'b0, 1'b0, 12'h000, 32'hF0F0F0F0, 32'hFFFF0000); tick();
    chk("eor", bus.ALU_result, 32'h0F0FF0F0);
    drive(4'b0111, 1'b0, 1'b0, 12'h000, 32'hF0, 32'h0F); tick();
    chk("orr", bus.ALU_result, 32'hFF);

    drive(4'b0010, 1'b0, 1'b0, 12'hFFF, 32'h1000, 32'hDEAD);
    bus.Mem_R_EN = 1'b1; bus.dest = 4'd3; tick();
    chk("ldr_addr", bus.ALU_result, 32'h1FFF);
    chk("ldr_ren", 32'(bus.Mem_R_EN_out), 32'h1);
    chk("ldr_dest", 32'(bus.dest_out), 32'h3);

    drive(4'b0010, 1'b0, 1'b0, 12'h010, 32'h2000, 32'hCAFEBABE);
    bus.Mem_W_EN = 1'b1; bus.WB_EN = 1'b0; tick();
    chk("str_addr", bus.ALU_result, 32'h2010);
    chk("str_data", bus.Val_Rm_out, 32'hCAFEBABE);
    chk("str_wen", 32'(bus.Mem_W_EN_out), 32'h1);
    chk("str_wb", 32'(bus.WB_EN_out), 32'h0);

    bus.B = 1'b1; bus.pc = 32'h100; bus.signed_imm_24 = 24'hFFFFFE; #1;
    chk("br_taken", 32'(bus.Branch_taken), 32'h1);
    chk("br_back", bus.Branch_Address, 32'hF8);
    bus.pc = 32'h0; bus.signed_imm_24 = 24'h000004; #1;
    chk("br_fwd", bus.Branch_Address, 32'h10);
    bus.pc = 32'hFFFFFFFC; bus.signed_imm_24 = 24'h000001; #1;
    chk("br_wrap", bus.Branch_Address, 32'h0);

    drive(4'b0100, 1'b1, 1'b1, 12'h005, 32'd3, 32'h0); tick();
    chk("sub_neg_res", bus.ALU_result, 32'hFFFFFFFE);
    chk("sub_neg_sr", 32'(bus.SR), 32'h8);
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 1'b1, 1'b1, 12'(i + 1), 32'd1, 32'h0);
      bus.dest = 4'(i + 8);
      tick();
      chk("frz_res", bus.ALU_result, 32'hFFFFFFFE);
      chk("frz_sr", 32'(bus.SR), 32'h8);
      chk("frz_dest", 32'(bus.dest_out), 32'h1);
    end
    bus.freeze = 1'b0;
    drive(4'b0010, 1'b1, 1'b1, 12'h001, 32'd1, 32'h0); tick();
    chk("unfrz_res", bus.ALU_result, 32'd2);
    chk("unfrz_sr", 32'(bus.SR), 32'h0);

`ifdef FORWARDING_EN
    drive(4'b0010, 1'b0, 1'b1, 12'h003, 32'd99, 32'h0);
    bus.sel_src1 = 2'b01; bus.MEM_ALU_result = 32'd10; tick();
    chk("fwd_mem_rn", bus.ALU_result, 32'd13);
    drive(4'b0001, 1'b0, 1'b0, 12'h000, 32'h0, 32'h7);
    bus.sel_src2 = 2'b10; bus.WB_Value = 32'h1234ABCD; tick();
    chk("fwd_wb_rm", bus.ALU_result, 32'h1234ABCD);
    chk("fwd_wb_store", bus.Val_Rm_out, 32'h1234ABCD);
`endif

    drive(4'b0010, 1'b1, 1'b1, 12'h001, 32'hFFFFFFFF, 32'h0); tick();
    chk("add_carry_sr", 32'(bus.SR), 32'h6);
    drive(4'b0001, 1'b0, 1'b0, 12'h000, 32'h0, 32'h1234); tick();
    chk("pre_rst_res", bus.ALU_result, 32'h1234);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_res", bus.ALU_result, 32'h0);
    chk("async_rst_sr", 32'(bus.SR), 32'h0);
    chk("async_rst_wb", 32'(bus.WB_EN_out), 32'h0);
    chk("async_rst_dest", 32'(bus.dest_out), 32'h0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
